// File: rtl/pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pic_host_sequencer
// Purpose  : Host-side bus sequencer for an 8259-style PIC. Runs the ICW/OCW
//            initialization sequence, forwards runtime command writes and
//            performs the two-pulse INTA acknowledge to capture the vector.
// Revision : 1.0 - initial release
// ============================================================================
module pic_host_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    input  logic       cmd_valid,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       INT,
    inout  wire  [7:0] data_Bus,
    output logic       chip_select,
    output logic       read_Enable,
    output logic       write_Enable,
    output logic       INTA,
    output logic       A0,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_SETUP  = 4'd1,
        W_PULSE  = 4'd2,
        W_HOLD   = 4'd3,
        W_GAP    = 4'd4,
        ACK1     = 4'd5,
        ACK_GAP  = 4'd6,
        ACK2     = 4'd7,
        ACK_DONE = 4'd8
    } state_t;

    // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
    localparam logic [3:0] c_pulse_load = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] c_gap_load   = 4'(GAP_CYCLES - 1);

    // Position inside the init sequence.
    localparam logic [2:0] c_step_icw1 = 3'd0;
    localparam logic [2:0] c_step_icw2 = 3'd1;
    localparam logic [2:0] c_step_icw3 = 3'd2;
    localparam logic [2:0] c_step_icw4 = 3'd3;
    localparam logic [2:0] c_step_ocw1 = 3'd4;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] step_q, step_d;
    logic       init_run_q, init_run_d;
    logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d;
    logic [7:0] icw4_q, icw4_d, ocw1_q, ocw1_d;
    logic       wr_a0_q, wr_a0_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       int_q;
    logic       init_done_q, init_done_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q, vector_valid_d;
    logic       cs_q, cs_d, we_q, we_d, inta_q, inta_d, a0_q, a0_d;
    logic       drive_q, drive_d;

    logic [2:0] w_next_step;
    logic [7:0] w_next_byte;

    // Pick the next init write, skipping ICW3 when single and ICW4 when unused.
    always_comb begin
        w_next_step = c_step_ocw1;
        w_next_byte = ocw1_q;
        case (step_q)
            c_step_icw1: w_next_step = c_step_icw2;
            c_step_icw2: w_next_step = !icw1_q[1] ? c_step_icw3 :
                                       (icw1_q[0] ? c_step_icw4 : c_step_ocw1);
            c_step_icw3: w_next_step = icw1_q[0] ? c_step_icw4 : c_step_ocw1;
            default:     w_next_step = c_step_ocw1;
        endcase
        case (w_next_step)
            c_step_icw2: w_next_byte = icw2_q;
            c_step_icw3: w_next_byte = icw3_q;
            c_step_icw4: w_next_byte = icw4_q;
            default:     w_next_byte = ocw1_q;
        endcase
    end

    // Next-state, counter, configuration and strobe computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        step_d      = step_q;
        init_run_d  = init_run_q;
        icw1_d      = icw1_q;
        icw2_d      = icw2_q;
        icw3_d      = icw3_q;
        icw4_d      = icw4_q;
        ocw1_d      = ocw1_q;
        wr_a0_d     = wr_a0_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;
        vector_d    = vector_q;

        case (state_q)
            IDLE: begin
                if (init_start) begin
                    icw1_d      = icw1;
                    icw2_d      = icw2;
                    icw3_d      = icw3;
                    icw4_d      = icw4;
                    ocw1_d      = ocw1;
                    init_done_d = 1'b0;
                    init_run_d  = 1'b1;
                    step_d      = c_step_icw1;
                    wr_a0_d     = 1'b0;
                    wr_data_d   = icw1;
                    state_d     = W_SETUP;
                    cnt_d       = 4'd0;
                end else if (cmd_valid && init_done_q) begin
                    init_run_d = 1'b0;
                    wr_a0_d    = cmd_a0;
                    wr_data_d  = cmd_data;
                    state_d    = W_SETUP;
                    cnt_d      = 4'd0;
                end else if (int_q && init_done_q) begin
                    state_d = ACK1;
                    cnt_d   = c_pulse_load;
                end
            end
            W_SETUP: begin
                state_d = W_PULSE;
                cnt_d   = c_pulse_load;
            end
            W_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = W_HOLD;
                    cnt_d   = 4'd0;
                end
            end
            W_HOLD: begin
                state_d = W_GAP;
                cnt_d   = c_gap_load;
            end
            W_GAP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d = 4'd0;
                    if (init_run_q && (step_q != c_step_ocw1)) begin
                        step_d    = w_next_step;
                        wr_a0_d   = 1'b1;
                        wr_data_d = w_next_byte;
                        state_d   = W_SETUP;
                    end else begin
                        if (init_run_q) begin
                            init_done_d = 1'b1;
                        end
                        init_run_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            ACK1: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK_GAP;
                    cnt_d   = c_gap_load;
                end
            end
            ACK_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK2;
                    cnt_d   = c_pulse_load;
                end
            end
            ACK2: begin
                if (cnt_q == 4'd0) begin
                    vector_d = data_Bus;
                    state_d  = ACK_DONE;
                    cnt_d    = 4'd0;
                end
            end
            ACK_DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Strobes are decoded from the upcoming state so the flops line up with it.
        cs_d           = 1'b1;
        we_d           = 1'b1;
        inta_d         = 1'b1;
        a0_d           = 1'b0;
        drive_d        = 1'b0;
        vector_valid_d = 1'b0;
        case (state_d)
            W_SETUP, W_HOLD: begin
                cs_d    = 1'b0;
                a0_d    = wr_a0_d;
                drive_d = 1'b1;
            end
            W_PULSE: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                a0_d    = wr_a0_d;
                drive_d = 1'b1;
            end
            ACK1, ACK2: inta_d         = 1'b0;
            ACK_DONE:   vector_valid_d = 1'b1;
            default: ;
        endcase
    end

    // State, counter and registered outputs; reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            step_q         <= c_step_icw1;
            init_run_q     <= 1'b0;
            icw1_q         <= 8'h00;
            icw2_q         <= 8'h00;
            icw3_q         <= 8'h00;
            icw4_q         <= 8'h00;
            ocw1_q         <= 8'h00;
            wr_a0_q        <= 1'b0;
            wr_data_q      <= 8'h00;
            int_q          <= 1'b0;
            init_done_q    <= 1'b0;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
            cs_q           <= 1'b1;
            we_q           <= 1'b1;
            inta_q         <= 1'b1;
            a0_q           <= 1'b0;
            drive_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            step_q         <= step_d;
            init_run_q     <= init_run_d;
            icw1_q         <= icw1_d;
            icw2_q         <= icw2_d;
            icw3_q         <= icw3_d;
            icw4_q         <= icw4_d;
            ocw1_q         <= ocw1_d;
            wr_a0_q        <= wr_a0_d;
            wr_data_q      <= wr_data_d;
            int_q          <= INT;
            init_done_q    <= init_done_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            cs_q           <= cs_d;
            we_q           <= we_d;
            inta_q         <= inta_d;
            a0_q           <= a0_d;
            drive_q        <= drive_d;
        end
    end

    assign data_Bus     = drive_q ? wr_data_q : 8'hzz;
    assign chip_select  = cs_q;
    assign write_Enable = we_q;
    assign read_Enable  = 1'b1;
    assign INTA         = inta_q;
    assign A0           = a0_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign init_done    = init_done_q;
    assign busy         = (state_q != IDLE);
    assign cmd_ready    = (state_q == IDLE) && init_done_q && !init_start;

endmodule
`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_host_sequencer
// Purpose  : Directed self-checking bench for pic_host_sequencer with a small
//            PIC bus model that answers the two INTA pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_host_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, ocw1 = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_a0 = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       INT = 1'b0;
    wire        cmd_ready;
    wire  [7:0] data_Bus;
    wire        chip_select, read_Enable, write_Enable, INTA, A0;
    wire  [7:0] vector;
    wire        vector_valid, init_done, busy;

    logic [7:0] pic_vec = 8'h23;
    logic       pic_second = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus monitor logs
    logic [9:0] wr_log[$];
    int wr_time[$], we_width[$], cs_width[$];
    int inta_width[$], inta_gap[$], inta_fall_time[$];
    int we_run = 0, cs_run = 0, inta_run = 0, inta_high = 0;
    int vv_count = 0, ack_bus_errs = 0, cyc = 0;
    logic [7:0] vv_vec = 8'h00;
    logic prev_we = 1'b1, prev_cs = 1'b1, prev_inta = 1'b1;

    pic_host_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
        .cmd_valid(cmd_valid), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .INT(INT), .data_Bus(data_Bus),
        .chip_select(chip_select), .read_Enable(read_Enable),
        .write_Enable(write_Enable), .INTA(INTA), .A0(A0),
        .vector(vector), .vector_valid(vector_valid),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // PIC model: decoy byte on the first INTA pulse, vector on the second.
    assign data_Bus = (!INTA && !reset) ? (pic_second ? pic_vec : 8'hCD) : 8'hzz;

    // Observe bus activity on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            pic_second = 1'b0;
            we_run = 0; cs_run = 0; inta_run = 0; inta_high = 0;
        end else begin
            if (!write_Enable) begin
                if (prev_we) begin
                    wr_log.push_back({chip_select, A0, data_Bus});
                    wr_time.push_back(cyc);
                end
                we_run++;
            end else if (!prev_we) begin
                we_width.push_back(we_run);
                we_run = 0;
            end
            if (!chip_select) cs_run++;
            else if (!prev_cs) begin
                cs_width.push_back(cs_run);
                cs_run = 0;
            end
            if (!INTA) begin
                if (prev_inta) begin
                    inta_fall_time.push_back(cyc);
                    if (inta_width.size() > 0) inta_gap.push_back(inta_high);
                    inta_high = 0;
                end
                inta_run++;
                if (!chip_select || !write_Enable) ack_bus_errs++;
            end else begin
                if (!prev_inta) begin
                    inta_width.push_back(inta_run);
                    inta_run = 0;
                    pic_second = !pic_second;
                end
                inta_high++;
            end
            if (vector_valid) begin
                vv_count++;
                vv_vec = vector;
            end
        end
        prev_we   = reset ? 1'b1 : write_Enable;
        prev_cs   = reset ? 1'b1 : chip_select;
        prev_inta = reset ? 1'b1 : INTA;
        cyc++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete(); wr_time.delete(); we_width.delete(); cs_width.delete();
        inta_width.delete(); inta_gap.delete(); inta_fall_time.delete();
        vv_count = 0; ack_bus_errs = 0;
    endtask

    // Launch an init sequence, scramble inputs after acceptance, poke a
    // masked init_start mid-sequence, and return cycles until init_done.
    task automatic run_init(input logic [7:0] i1, i2, i3, i4, o1, output int n);
        clear_logs();
        icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw1 = o1;
        init_start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                init_start = 1'b0;
                icw1 = 8'hEE; icw2 = 8'hEE; icw3 = 8'hEE; icw4 = 8'hEE; ocw1 = 8'hEE;
            end
            if (n == 6) init_start = 1'b1;
            if (n == 7) init_start = 1'b0;
        end while (!init_done && n < 100);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 50) begin tick(); k++; end
        if (k >= 50) check_value(tag, 32'(busy), 32'd0);
    endtask

    function automatic logic [9:0] log_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 10'h3FF;
    endfunction

    initial begin
        int n;
        int k;
        logic [9:0] exp13 [4];
        logic [9:0] exp11 [5];
        exp13 = '{10'h013, 10'h120, 10'h101, 10'h1FB};
        exp11 = '{10'h011, 10'h108, 10'h104, 10'h101, 10'h1FB};

        // Reset state
        repeat (3) tick();
        check_value("rst_cs",   32'(chip_select),  32'd1);
        check_value("rst_we",   32'(write_Enable), 32'd1);
        check_value("rst_re",   32'(read_Enable),  32'd1);
        check_value("rst_inta", 32'(INTA),         32'd1);
        check_value("rst_a0",   32'(A0),           32'd0);
        check_value("rst_vec",  32'(vector),       32'h00);
        check_value("rst_vv",   32'(vector_valid), 32'd0);
        check_value("rst_done", 32'(init_done),    32'd0);
        check_value("rst_busy", 32'(busy),         32'd0);
        check_value("rst_rdy",  32'(cmd_ready),    32'd0);
        reset = 1'b0;
        tick();

        // INT before init must not be acknowledged
        clear_logs();
        INT = 1'b1;
        repeat (6) tick();
        check_value("preinit_inta", 32'(inta_fall_time.size()), 32'd0);
        check_value("preinit_busy", 32'(busy), 32'd0);
        INT = 1'b0;
        repeat (2) tick();

        // Single, no ICW4: ICW1, ICW2, OCW1
        run_init(8'h12, 8'h40, 8'h55, 8'h66, 8'h7F, n);
        check_value("init12_cycles", 32'(n), 32'd16);
        check_value("init12_nwr", 32'(wr_log.size()), 32'd3);
        check_value("init12_wr0", 32'(log_at(0)), 32'h012);
        check_value("init12_wr1", 32'(log_at(1)), 32'h140);
        check_value("init12_wr2", 32'(log_at(2)), 32'h17F);

        // Single with ICW4: four writes, done at cycle 21
        run_init(8'h13, 8'h20, 8'h99, 8'h01, 8'hFB, n);
        check_value("init13_cycles", 32'(n), 32'd21);
        check_value("init13_nwr", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("init13_wr%0d", i), 32'(log_at(i)), 32'(exp13[i]));
        check_value("init13_we_w", (we_width.size() > 0) ? 32'(we_width[0]) : 32'hFFFF, 32'd2);
        check_value("init13_cs_w", (cs_width.size() > 0) ? 32'(cs_width[0]) : 32'hFFFF, 32'd4);
        check_value("init13_period", (wr_time.size() > 1) ? 32'(wr_time[1] - wr_time[0]) : 32'hFFFF, 32'd5);

        // cmd_ready is masked by a same-cycle init_start
        check_value("rdy_idle", 32'(cmd_ready), 32'd1);
        init_start = 1'b1;
        #1;
        check_value("rdy_masked", 32'(cmd_ready), 32'd0);
        init_start = 1'b0;
        #1;
        tick();

        // Acknowledge; INT drops during the first pulse
        clear_logs();
        pic_vec = 8'h23;
        INT = 1'b1;
        k = 0;
        while (INTA && k < 20) begin tick(); k++; end
        check_value("ack_started", 32'(INTA), 32'd0);
        INT = 1'b0;
        wait_idle("ack_timeout");
        tick();
        check_value("ack_npulse", 32'(inta_width.size()), 32'd2);
        check_value("ack_w0", (inta_width.size() > 0) ? 32'(inta_width[0]) : 32'hFFFF, 32'd2);
        check_value("ack_w1", (inta_width.size() > 1) ? 32'(inta_width[1]) : 32'hFFFF, 32'd2);
        check_value("ack_gap", (inta_gap.size() > 0) ? 32'(inta_gap[0]) : 32'hFFFF, 32'd1);
        check_value("ack_vv_cnt", 32'(vv_count), 32'd1);
        check_value("ack_vv_vec", 32'(vv_vec), 32'h23);
        check_value("ack_vec_hold", 32'(vector), 32'h23);
        check_value("ack_bus_quiet", 32'(ack_bus_errs), 32'd0);
        check_value("ack_no_write", 32'(wr_log.size()), 32'd0);

        // Cascade: ICW3 included as third write
        run_init(8'h11, 8'h08, 8'h04, 8'h01, 8'hFB, n);
        check_value("init11_cycles", 32'(n), 32'd26);
        check_value("init11_nwr", 32'(wr_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check_value($sformatf("init11_wr%0d", i), 32'(log_at(i)), 32'(exp11[i]));

        // Command and INT together: write wins, ack follows; a command
        // raised during the ack is held off and written afterwards.
        clear_logs();
        pic_vec = 8'h47;
        INT = 1'b1; cmd_valid = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h20;
        check_value("cmd_rdy", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (INTA && k < 30) begin tick(); k++; end
        check_value("cmd_ack_started", 32'(INTA), 32'd0);
        INT = 1'b0;
        cmd_valid = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h0B;
        k = 0;
        while (!cmd_ready && k < 30) begin tick(); k++; end
        check_value("cmd_rdy_after_ack", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        wait_idle("cmd_timeout");
        tick();
        check_value("cmd_nwr", 32'(wr_log.size()), 32'd2);
        check_value("cmd_wr0", 32'(log_at(0)), 32'h020);
        check_value("cmd_wr1", 32'(log_at(1)), 32'h10B);
        check_value("cmd_order_a", (wr_time.size() > 0 && inta_fall_time.size() > 0) ?
                    32'(wr_time[0] < inta_fall_time[0]) : 32'd0, 32'd1);
        check_value("cmd_order_b", (wr_time.size() > 1 && inta_fall_time.size() > 0) ?
                    32'(inta_fall_time[0] < wr_time[1]) : 32'd0, 32'd1);
        check_value("cmd_vec", 32'(vector), 32'h47);

        // Reset while write_Enable is low
        clear_logs();
        icw1 = 8'h13; icw2 = 8'h20; icw4 = 8'h01; ocw1 = 8'hFB;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        k = 0;
        while (write_Enable && k < 10) begin tick(); k++; end
        check_value("rstmid_in_pulse", 32'(write_Enable), 32'd0);
        reset = 1'b1;
        tick();
        check_value("rstmid_we",   32'(write_Enable), 32'd1);
        check_value("rstmid_cs",   32'(chip_select),  32'd1);
        check_value("rstmid_done", 32'(init_done),    32'd0);
        check_value("rstmid_busy", 32'(busy),         32'd0);
        check_value("rstmid_vec",  32'(vector),       32'h00);
        check_value("rstmid_a0",   32'(A0),           32'd0);
        reset = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pic_host_sequencer.md
PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2: low width in clk cycles of every WR_n and INTA_n pulse; legal range 1-15.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: idle cycles after every bus write and between the two INTA pulses; legal range 1-15.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port init_start  input  1  one-cycle request to run the initialization sequence.
REQ-006 SHALL have ports icw1, icw2, icw3, icw4, ocw1  input  8 each  configuration bytes, sampled into internal registers on the accepted init_start.
REQ-007 SHALL have ports cmd_valid  input  1; cmd_a0  input  1; cmd_data  input  8: runtime command-write request (OCW1/2/3).
REQ-008 SHALL have port cmd_ready  output  1  high when a runtime command is accepted this cycle.
REQ-009 SHALL have port INT  input  1  interrupt request from the PIC, active-high.
REQ-010 SHALL have port data_Bus  inout  8  PIC data bus; driven only during write cycles, otherwise high-Z.
REQ-011 SHALL have ports chip_select, read_Enable, write_Enable, INTA  output  1 each  PIC strobes, all active-low.
REQ-012 SHALL have port A0  output  1  PIC register select.
REQ-013 SHALL have ports vector  output  8  captured interrupt vector; vector_valid  output  1  one-cycle pulse on capture.
REQ-014 SHALL have ports init_done  output  1  set after the final init write; busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, W_SETUP, W_PULSE, W_HOLD, W_GAP, ACK1, ACK_GAP, ACK2, ACK_DONE.
REQ-016 Write cycle SHALL be: W_SETUP 1 cycle (chip_select=0, A0 and data_Bus driven) -> W_PULSE PULSE_CYCLES (write_Enable=0) -> W_HOLD 1 cycle (write_Enable=1, data still driven) -> W_GAP GAP_CYCLES (chip_select=1, bus high-Z).
REQ-017 Init sequence SHALL write ICW1 (A0=0), ICW2 (A0=1), ICW3 (A0=1) only if icw1[1]=0, ICW4 (A0=1) only if icw1[0]=1, then OCW1 (A0=1), in that order.
REQ-018 init_done SHALL go 0 when init_start is accepted and 1 on the cycle after the OCW1 W_GAP ends.
REQ-019 Arbitration in IDLE SHALL be: init_start > cmd_valid > INT; init_start while busy SHALL be ignored.
REQ-020 cmd_ready SHALL equal (state==IDLE && init_done && !init_start); runtime writes accepted on cmd_valid&&cmd_ready use cmd_a0/cmd_data.
REQ-021 INT SHALL be registered once; an acknowledge SHALL start only from IDLE when registered INT=1 and init_done=1.
REQ-022 Acknowledge SHALL be: ACK1 INTA=0 for PULSE_CYCLES -> ACK_GAP INTA=1 for GAP_CYCLES -> ACK2 INTA=0 for PULSE_CYCLES -> ACK_DONE 1 cycle; chip_select and write_Enable stay 1, data_Bus high-Z throughout.
REQ-023 vector SHALL load data_Bus on the last ACK2 cycle; vector_valid SHALL pulse during ACK_DONE; vector holds until next capture.
REQ-024 read_Enable SHALL remain 1 at all times (status reads out of scope).
REQ-025 A single 4-bit down-counter SHALL time all phases; it reloads on every state entry.
REQ-026 INT dropping mid-acknowledge SHALL NOT abort the sequence; vector is captured regardless.
REQ-027 cmd_valid or INT arriving while busy SHALL be held off (not lost for cmd_valid; INT re-evaluated in IDLE).

Reset
REQ-028 reset SHALL force, on the next edge: state IDLE, chip_select=write_Enable=read_Enable=INTA=1, A0=0, data_Bus high-Z, vector=0x00, vector_valid=0, init_done=0, busy=0, counter=0.
REQ-029 reset asserted mid-write or mid-acknowledge SHALL abort immediately with the REQ-028 values; no partial pulse completes.

Verification
REQ-030 Init icw1=0x13, icw2=0x20, icw4=0x01, ocw1=0xFB, defaults -> 4 writes (0x13/A0=0, 0x20, 0x01, 0xFB/A0=1), each 5 cycles, no ICW3, init_done=1 at cycle 21.
REQ-031 Init icw1=0x11 (cascade), icw3=0x04 -> 5 writes including 0x04 as third write.
REQ-032 After init, INT=1, PIC model drives 0x23 during second INTA -> two INTA pulses of 2 cycles separated by 1; vector=0x23, vector_valid pulse 1 cycle.
REQ-033 cmd_valid with cmd_a0=0, cmd_data=0x20 and INT=1 same cycle -> command write first, then acknowledge.
REQ-034 INT=1 before init_done -> no INTA pulse; reset during W_PULSE -> write_Enable=1, chip_select=1, init_done=0 next cycle.
